riscv_dmem_arbiter: RTL

Two-port arbiter that shares the single data-memory port behind the IO bridge between the CPU load/store path (port 0) and a secondary master (port 1: UART program loader or a future DMA engine). Round-robin arbitration with an optional lock for multi-access sequences. A program-mode override gives port 1 exclusive ownership. One access per cycle; the memory read latency is 1 cycle.

---
 rtl/riscv_dmem_arbiter_pkg.sv | 28 ++
 rtl/riscv_rr_pick2.sv | 36 +++
 rtl/riscv_dmem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared port ids and lock-owner encodings for the data-memory arbiter.
// Pure definitions; no latency and no flow control of its own.
package riscv_dmem_arbiter_pkg;

  localparam logic ARB_ID_P0 = 1'b0;
  localparam logic ARB_ID_P1 = 1'b1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_own_e;

  function automatic lock_own_e lock_of(input logic id);
    return (id == ARB_ID_P1) ? LOCK_P1 : LOCK_P0;
  endfunction

  // Program mode beats any lock; a lock restricts eligibility to its owner even when idle.
  function automatic logic [1:0] eligible_mask(input logic prog, input lock_own_e own);
    logic [1:0] m;
    m = 2'b11;
    if (prog)                m = 2'b10;
    else if (own == LOCK_P0) m = 2'b01;
    else if (own == LOCK_P1) m = 2'b10;
    return m;
  endfunction

endpackage

// File: rtl/riscv_rr_pick2.sv
// Two-way round-robin pick among masked valid requesters.
// Combinational, zero latency; no backpressure of its own.
module riscv_rr_pick2
  import riscv_dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic [1:0] cand;

  always_comb begin
    cand   = valid & mask;
    gnt    = 2'b00;
    gnt_id = ARB_ID_P0;
    case (cand)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = ARB_ID_P0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = ARB_ID_P1;
      end
      2'b11: begin
        gnt_id = ~last;
        gnt    = last ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and a loader/DMA (port 1).
// One accept per cycle, response one cycle later; a port waits while not selected.
module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_mode,

  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic                p0_req_we,
  input  logic                p0_req_lock,
  input  logic [ADDR_W-1:0]   p0_req_addr,
  input  logic [DATA_W-1:0]   p0_req_wdata,
  input  logic [DATA_W/8-1:0] p0_req_wstrb,
  output logic                p0_rsp_valid,
  output logic [DATA_W-1:0]   p0_rsp_rdata,

  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic                p1_req_we,
  input  logic                p1_req_lock,
  input  logic [ADDR_W-1:0]   p1_req_addr,
  input  logic [DATA_W-1:0]   p1_req_wdata,
  input  logic [DATA_W/8-1:0] p1_req_wstrb,
  output logic                p1_rsp_valid,
  output logic [DATA_W-1:0]   p1_rsp_rdata,

  output logic                stall_cpu,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic      last_gnt_q, last_gnt_d;
  lock_own_e lock_own_q, lock_own_d;
  logic      rsp_v_q, rsp_v_d;
  logic      rsp_id_q, rsp_id_d;
  logic      rsp_rd_q, rsp_rd_d;

  logic [1:0] mask;
  logic [1:0] gnt;
  logic [1:0] gnt_ok;
  logic       gnt_id;
  logic       accept;
  logic       sel_we;
  logic       sel_lock;
  logic       rsp_fire;

  assign mask = eligible_mask(prog_mode, lock_own_q);

  riscv_rr_pick2 u_pick (
    .valid  ({p1_req_valid, p0_req_valid}),
    .last   (last_gnt_q),
    .mask   (mask),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Nothing is accepted while reset is held.
  assign gnt_ok       = gnt & {2{~rst}};
  assign accept       = |gnt_ok;
  assign p0_req_ready = gnt_ok[0];
  assign p1_req_ready = gnt_ok[1];
  assign stall_cpu    = p0_req_valid & ~p0_req_ready;

  assign sel_we   = (gnt_id == ARB_ID_P1) ? p1_req_we   : p0_req_we;
  assign sel_lock = (gnt_id == ARB_ID_P1) ? p1_req_lock : p0_req_lock;

  always_comb begin
    mem_en    = accept;
    mem_we    = accept & sel_we;
    mem_addr  = (gnt_id == ARB_ID_P1) ? p1_req_addr  : p0_req_addr;
    mem_wdata = (gnt_id == ARB_ID_P1) ? p1_req_wdata : p0_req_wdata;
    mem_wstrb = '0;
    if (accept && sel_we)
      mem_wstrb = (gnt_id == ARB_ID_P1) ? p1_req_wstrb : p0_req_wstrb;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    lock_own_d = lock_own_q;
    rsp_v_d    = accept;
    rsp_id_d   = gnt_id;
    rsp_rd_d   = ~sel_we;
    if (accept) begin
      last_gnt_d = gnt_id;
      lock_own_d = sel_lock ? lock_of(gnt_id) : LOCK_NONE;
    end else if (prog_mode && lock_own_q == LOCK_P0) begin
      // The loader takes over; the CPU's multi-access sequence is abandoned.
      lock_own_d = LOCK_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= ARB_ID_P1;
      lock_own_q <= LOCK_NONE;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= ARB_ID_P0;
      rsp_rd_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_own_q <= lock_own_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

  // Gating with rst drops a response whose access was accepted just before reset.
  assign rsp_fire     = rsp_v_q & ~rst;
  assign p0_rsp_valid = rsp_fire & (rsp_id_q == ARB_ID_P0);
  assign p1_rsp_valid = rsp_fire & (rsp_id_q == ARB_ID_P1);
  assign p0_rsp_rdata = rsp_rd_q ? mem_rdata : '0;
  assign p1_rsp_rdata = rsp_rd_q ? mem_rdata : '0;

endmodule
